// File: rtl/u_tx.sv
// u_tx: UART serial transmitter.
// A one-deep holding register takes words over a valid/ready handshake.
// Each word is sent LSB-first as a start bit, the data bits, an optional
// parity bit and the stop bit(s). Bit timing comes from the baud_en_tx
// strobe, which pulses no_of_sample times per serial bit.
// Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit
// (XOR of the data bits) between the last data bit and the stop bit(s).
module u_tx #(
  parameter int width        = 8,
  parameter int no_of_sample = 16,
  parameter int stop_bits    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             baud_en_tx,
  input  logic [width-1:0] tx_data_in,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             tx_out,
  output logic             tx_active,
  output logic             tx_done
);

  // Counter widths are forced to at least one bit so that width=1 or
  // no_of_sample=1 still elaborate. bit_index also counts stop bits.
  localparam int SC_W = (no_of_sample > 1) ? $clog2(no_of_sample) : 1;
  localparam int BI_W = (width > 1) ? $clog2(width) : 1;

  localparam logic [SC_W-1:0] SC_LAST   = SC_W'(no_of_sample - 1);
  localparam logic [BI_W-1:0] BI_LAST   = BI_W'(width - 1);
  localparam logic [BI_W-1:0] STOP_LAST = BI_W'(stop_bits - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t           state_q, state_d;
  logic             hold_valid_q, hold_valid_d;
  logic [width-1:0] hold_data_q, hold_data_d;
  logic [width-1:0] shift_q, shift_d;
  logic [SC_W-1:0]  sample_count_q, sample_count_d;
  logic [BI_W-1:0]  bit_index_q, bit_index_d;
  logic             tx_out_q, tx_out_d;
  logic             tx_active_q, tx_active_d;
  logic             tx_done_q, tx_done_d;
  logic             load;
  logic             sc_last;
`ifdef UART_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  assign sc_last   = (sample_count_q == SC_LAST);
  assign tx_ready  = !hold_valid_q;
  assign tx_out    = tx_out_q;
  assign tx_active = tx_active_q;
  assign tx_done   = tx_done_q;

  // Next-state logic: frame sequencing on baud ticks, plus the holding register.
  always_comb begin
    state_d        = state_q;
    hold_valid_d   = hold_valid_q;
    hold_data_d    = hold_data_q;
    shift_d        = shift_q;
    sample_count_d = sample_count_q;
    bit_index_d    = bit_index_q;
    tx_out_d       = tx_out_q;
    tx_active_d    = tx_active_q;
    tx_done_d      = 1'b0;
    load           = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d       = parity_q;
`endif

    if (baud_en_tx) begin
      case (state_q)
        IDLE: begin
          tx_out_d = 1'b1;
          if (hold_valid_q) begin
            load           = 1'b1;
            tx_out_d       = 1'b0;
            tx_active_d    = 1'b1;
            sample_count_d = '0;
            state_d        = START;
          end
        end
        START: begin
          if (sc_last) begin
            sample_count_d = '0;
            bit_index_d    = '0;
            tx_out_d       = shift_q[0];
            state_d        = DATA;
          end else begin
            sample_count_d = sample_count_q + 1'b1;
          end
        end
        DATA: begin
          if (sc_last) begin
            sample_count_d = '0;
            if (bit_index_q == BI_LAST) begin
`ifdef UART_TX_PARITY_EN
              tx_out_d = parity_q;
              state_d  = PARITY;
`else
              bit_index_d = '0;
              tx_out_d    = 1'b1;
              state_d     = STOP;
`endif
            end else begin
              bit_index_d = bit_index_q + 1'b1;
              shift_d     = shift_q >> 1;
              tx_out_d    = shift_d[0];
            end
          end else begin
            sample_count_d = sample_count_q + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (sc_last) begin
            sample_count_d = '0;
            bit_index_d    = '0;
            tx_out_d       = 1'b1;
            state_d        = STOP;
          end else begin
            sample_count_d = sample_count_q + 1'b1;
          end
        end
`endif
        STOP: begin
          if (sc_last) begin
            sample_count_d = '0;
            if (bit_index_q == STOP_LAST) begin
              tx_done_d = 1'b1;
              if (hold_valid_q) begin
                // Back-to-back: the next start bit follows with no idle gap.
                load     = 1'b1;
                tx_out_d = 1'b0;
                state_d  = START;
              end else begin
                tx_out_d    = 1'b1;
                tx_active_d = 1'b0;
                state_d     = IDLE;
              end
            end else begin
              bit_index_d = bit_index_q + 1'b1;
            end
          end else begin
            sample_count_d = sample_count_q + 1'b1;
          end
        end
        default: begin
          tx_out_d    = 1'b1;
          tx_active_d = 1'b0;
          state_d     = IDLE;
        end
      endcase
    end

    // Drain and write never coincide: one needs hold_valid high, the other low.
    if (load) begin
      shift_d      = hold_data_q;
      hold_valid_d = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_d     = ^hold_data_q;
`endif
    end else if (tx_valid && !hold_valid_q) begin
      hold_valid_d = 1'b1;
      hold_data_d  = tx_data_in;
    end
  end

  // State and datapath registers; reset aborts any frame in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      hold_valid_q   <= 1'b0;
      hold_data_q    <= '0;
      shift_q        <= '0;
      sample_count_q <= '0;
      bit_index_q    <= '0;
      tx_out_q       <= 1'b1;
      tx_active_q    <= 1'b0;
      tx_done_q      <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q       <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      hold_valid_q   <= hold_valid_d;
      hold_data_q    <= hold_data_d;
      shift_q        <= shift_d;
      sample_count_q <= sample_count_d;
      bit_index_q    <= bit_index_d;
      tx_out_q       <= tx_out_d;
      tx_active_q    <= tx_active_d;
      tx_done_q      <= tx_done_d;
`ifdef UART_TX_PARITY_EN
      parity_q       <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_u_tx.sv
// tb_u_tx: directed bench for u_tx. Words are pushed to an expected queue
// when accepted; a line monitor rebuilds each frame from tx_out on baud
// ticks and pops/compares. A second instance covers two stop bits.
module tb_u_tx;

  localparam int W  = 8;
  localparam int N  = 16;
`ifdef UART_TX_PARITY_EN
  localparam int P  = 1;
`else
  localparam int P  = 0;
`endif
  localparam int NB  = 1 + W + P + 1;
  localparam int NB2 = 1 + W + P + 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         baud_en_tx = 1'b0;
  logic [W-1:0] tx_data_in = '0;
  logic         tx_valid = 1'b0;
  logic         tx_ready, tx_out, tx_active, tx_done;
  logic [W-1:0] tx_data2 = '0;
  logic         tx_valid2 = 1'b0;
  logic         tx_ready2, tx_out2, tx_active2, tx_done2;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  int frames_done = 0;
  int done_cnt = 0;
  int last_gap = 0;

  u_tx #(.width(W), .no_of_sample(N), .stop_bits(1)) dut (
    .clk(clk), .rst(rst), .baud_en_tx(baud_en_tx),
    .tx_data_in(tx_data_in), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_out(tx_out), .tx_active(tx_active), .tx_done(tx_done)
  );

  u_tx #(.width(W), .no_of_sample(N), .stop_bits(2)) dut2 (
    .clk(clk), .rst(rst), .baud_en_tx(baud_en_tx),
    .tx_data_in(tx_data2), .tx_valid(tx_valid2), .tx_ready(tx_ready2),
    .tx_out(tx_out2), .tx_active(tx_active2), .tx_done(tx_done2)
  );

  always #5 clk = ~clk;

  // Baud strobe: one clk in every four, changed 1 time unit after posedge.
  initial begin
    int div;
    div = 0;
    forever begin
      @(posedge clk);
      #1;
      baud_en_tx = (div == 3);
      div = (div + 1) % 4;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] frame_of(input logic [W-1:0] d, input int nstop);
    logic [31:0] f;
    int idx;
    f = '0;
    f[0] = 1'b0;
    for (int i = 0; i < W; i++) f[1+i] = d[i];
    idx = 1 + W;
    if (P == 1) begin
      f[idx] = ^d;
      idx++;
    end
    for (int i = 0; i < nstop; i++) f[idx+i] = 1'b1;
    return f;
  endfunction

  // Line monitor: at a negedge where baud_en_tx is high, tx_out holds the
  // value for the tick period that the coming posedge closes.
  initial begin
    bit          in_frame;
    int          s, gap, act_cnt;
    bit          glitch;
    logic [31:0] fb;
    logic [W-1:0] w, got;
    in_frame = 0; s = 0; gap = 0; act_cnt = 0; glitch = 0; fb = '0;
    forever begin
      @(negedge clk);
      if (tx_done === 1'b1) done_cnt++;
      if (rst) begin
        in_frame = 0;
        gap = 0;
      end else if (baud_en_tx) begin
        if (!in_frame) begin
          if (tx_out === 1'b0) begin
            in_frame = 1; s = 0; glitch = 0; act_cnt = 0; fb = '0;
            last_gap = gap; gap = 0;
          end else begin
            gap++;
          end
        end
        if (in_frame) begin
          if (s % N == 0) fb[s/N] = tx_out;
          else if (tx_out !== fb[s/N]) glitch = 1;
          if (tx_active === 1'b1) act_cnt++;
          s++;
          if (s == NB * N) begin
            in_frame = 0;
            check("frame_expected", exp_q.size() > 0, 1);
            w = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            for (int i = 0; i < W; i++) got[i] = fb[1+i];
            $display("frame: data 0x%0h expected 0x%0h active_ticks %0d", got, w, act_cnt);
            check("frame_data", got, w);
            check("frame_bits", fb, frame_of(w, 1));
            check("bit_width_stable", glitch, 0);
            check("active_ticks", act_cnt, NB * N);
            frames_done++;
          end
        end
      end
    end
  end

  task automatic send(input logic [W-1:0] w);
    int n;
    n = 0;
    while (tx_ready !== 1'b1 && n < 3000) begin
      @(posedge clk); #1; n++;
    end
    check("ready_wait", n < 3000, 1);
    tx_data_in = w;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    exp_q.push_back(w);
    $display("send: 0x%0h", w);
    tx_data_in = W'($urandom);
  endtask

  task automatic wait_frames(input int target);
    int n;
    n = 0;
    while (frames_done < target && n < 20000) begin
      @(posedge clk); #1; n++;
    end
    check("frame_count", frames_done, target);
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic next_tick();
    do @(negedge clk); while (baud_en_tx !== 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, base_done, high_cnt, zeros;
    logic [31:0] fb2;
    logic [W-1:0] got2;

    // Reset values.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_out", tx_out, 1);
    check("rst_tx_active", tx_active, 0);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_tx_done", tx_done, 0);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // Single frame and ready latency.
    send(8'hA5);
    check("ready_low_after_accept", tx_ready, 0);
    n = 0;
    while (tx_ready !== 1'b1 && n < 10) begin
      @(posedge clk); #1; n++;
    end
    $display("ready_latency: %0d clks", n);
    check("ready_latency_1_to_4", (n >= 1 && n <= 4), 1);
    wait_frames(1);
    check("done_pulses_1", done_cnt, 1);

    // Back-to-back frames; third write refused.
    send(8'h3C);
    repeat (100) @(posedge clk);
    #1;
    send(8'hFF);
    check("ready_low_when_full", tx_ready, 0);
    tx_data_in = 8'h11;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    wait_frames(3);
    check("zero_gap", last_gap, 0);
    check("done_pulses_3", done_cnt, 3);
    repeat (800) @(posedge clk);
    #1;
    check("no_extra_frame", frames_done, 3);
    check("queue_empty", exp_q.size(), 0);

    // Reset in the middle of a frame.
    send(8'h55);
    repeat (150) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    check("abort_tx_out", tx_out, 1);
    check("abort_tx_active", tx_active, 0);
    check("abort_tx_ready", tx_ready, 1);
    repeat (4) @(posedge clk);
    #1;
    send(8'h0F);
    wait_frames(4);

    // Stream of boundary words and parity patterns.
    send(8'h00);
    send(8'hFF);
    send(8'h81);
    send(8'h07);
    send(8'h03);
    wait_frames(9);
    check("done_pulses_9", done_cnt, 9);

    // Two stop bits on the second instance.
    tx_data2 = 8'hAA;
    tx_valid2 = 1'b1;
    @(posedge clk); #1;
    tx_valid2 = 1'b0;
    $display("send2: 0xaa");
    n = 0;
    do begin
      next_tick(); n++;
    end while (tx_out2 !== 1'b0 && n < 20);
    check("dut2_start_seen", tx_out2, 0);
    fb2 = '0;
    high_cnt = 0;
    for (int s = 0; s < NB2 * N; s++) begin
      if (s > 0) next_tick();
      if (s % N == N / 2) fb2[s/N] = tx_out2;
      if (s >= (1 + W + P) * N && tx_out2 === 1'b1) high_cnt++;
    end
    for (int i = 0; i < W; i++) got2[i] = fb2[1+i];
    $display("frame2: data 0x%0h stop_high_ticks %0d", got2, high_cnt);
    check("dut2_data", got2, 8'hAA);
    check("dut2_frame_bits", fb2, frame_of(8'hAA, 2));
    check("dut2_stop_high_ticks", high_cnt, 2 * N);
    base_done = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (tx_done2 === 1'b1) base_done++;
    end
    check("dut2_done_pulse", base_done, 1);
    zeros = 0;
    for (int s = 0; s < 2 * N; s++) begin
      next_tick();
      if (tx_out2 !== 1'b1) zeros++;
    end
    check("dut2_idle_high", zeros, 0);
    check("dut2_idle_inactive", tx_active2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/u_tx.md
Name: u_tx

Overview:
UART serial transmitter. It is the transmit-side counterpart of the u_rx receiver and shares its baud-enable and oversample conventions.
- Accepts parallel words over a valid/ready handshake into a one-deep holding register.
- Serializes each word LSB-first as start bit, data bits, optional parity bit, then stop bit(s).
- Bit timing comes from an external oversampled baud-enable strobe, the same tick source used by the receiver.

Parameters:
- width, 8: data bits per frame (1..16).
- no_of_sample, 16: baud_en_tx ticks per serial bit. Must equal the receiver's no_of_sample.
- stop_bits, 1: number of stop bits (1 or 2).

Ports:
- clk, input, 1: system clock, all logic on rising edge.
- rst, input, 1: synchronous, active-high reset.
- baud_en_tx, input, 1: one-clk strobe at no_of_sample × baud rate.
- tx_data_in, input, width: word to transmit.
- tx_valid, input, 1: tx_data_in is valid.
- tx_ready, output, 1: holding register empty; a word is accepted when tx_valid && tx_ready at a clk edge.
- tx_out, output, 1: serial line, idle high.
- tx_active, output, 1: a frame is on the line (start bit through last stop bit).
- tx_done, output, 1: one-clk pulse at the end of the last stop bit of each frame.

Behaviour:
- Reset values: tx_out=1, tx_active=0, tx_done=0, tx_ready=1. Reset also clears the state to IDLE, the holding register valid flag, sample_count and bit_index.
- Reset mid-frame aborts the frame immediately: tx_out=1 on the next clk and the held word is discarded.
- Handshake:
  - tx_ready = !hold_valid, taken directly from a register.
  - Acceptance happens on any clk edge and is not gated by baud_en_tx.
  - tx_data_in is sampled only at acceptance; later changes are ignored.
  - tx_valid while tx_ready=0 is ignored.
- FSM states: IDLE, START, DATA, PARITY, STOP. The FSM, sample_count and bit_index advance only on clk edges where baud_en_tx=1.
- IDLE:
  - tx_out=1, tx_active=0.
  - On a baud tick with hold_valid=1: load the shift register from the holding register and clear hold_valid (tx_ready returns to 1 next clk).
  - In the same tick: tx_out<=0, tx_active<=1, sample_count<=0, go to START.
- START: tx_out=0 for no_of_sample ticks. At sample_count==no_of_sample-1: sample_count<=0, bit_index<=0, drive bit 0, go to DATA.
- DATA:
  - Each bit is held for no_of_sample ticks, LSB first.
  - At the end of bit width-1, go to PARITY if the parity feature is compiled in, otherwise go to STOP.
- PARITY (feature only): drive the parity bit for no_of_sample ticks, then go to STOP.
- STOP:
  - tx_out=1 for stop_bits × no_of_sample ticks.
  - On the final tick: tx_done=1 for that one clk.
  - Then, if hold_valid=1, load the next word and go straight to START (back-to-back frames, zero idle gap).
  - Otherwise go to IDLE with tx_active<=0.
- Frame length: (1 + width + P + stop_bits) × no_of_sample ticks, where P=1 with parity, else 0.
- Latency from acceptance while idle: tx_out falls on the first baud_en_tx tick after the accepting clk.
- Simultaneous events:
  - A write while a frame is in progress fills the holding register; the active frame is unaffected.
  - Drain and write cannot coincide, because a write requires hold_valid=0 and a drain requires hold_valid=1.
- Counters: sample_count is ceil(log2(no_of_sample)) bits wide and wraps only via explicit reset to 0; bit_index is ceil(log2(width)) bits wide.
- tx_out, tx_active and tx_done are registered; there is no combinational path from inputs to outputs except tx_ready, which comes from a register.

Optional Feature:
- UART_TX_PARITY_EN defined:
  - The PARITY state is present and inserts an even-parity bit (XOR of all data bits) between the last data bit and the stop bit(s).
  - The peer receiver must be configured to match.
- Not defined: the PARITY state and its logic are absent, and DATA goes directly to STOP.

Test Plan:
1. Reset, then tx_data_in=8'hA5 with a one-clk tx_valid, baud_en_tx every 4 clks → tx_ready low for 1..4 clks. tx_out sequence per 16 ticks: 0, 1,0,1,0,0,1,0,1, then 1. Exactly one tx_done pulse; tx_active high for 160 ticks.
2. Write 8'h3C, then write 8'hFF while the first frame is in DATA → second start bit begins on the tick after the first stop bit ends, with no idle ticks. tx_done pulses twice. A third write during the first frame is refused (tx_ready=0).
3. Assert rst during DATA of 8'h55 → next clk: tx_out=1, tx_active=0, tx_ready=1. A subsequent 8'h0F frame transmits correctly.
4. Loopback tx_out into u_rx (same no_of_sample and baud tick), sending 8'h00, 8'hFF and 8'h81 → rx_data_ready pulses with data_out matching each word.
5. With UART_TX_PARITY_EN and data 8'h07 → parity bit=1 after bit 7; with data 8'h03 → parity bit=0. Frame length is 176 ticks.
6. stop_bits=2, data 8'hAA → 32 high ticks after bit 7 before tx_done, then tx_out stays 1 in IDLE.
